mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous memory between instruction fetch and the MEM-stage data access of the 5-stage pipeline.
- Data accesses have fixed priority over fetch. Every access is sequenced through a fixed-latency issue/wait/done FSM.
- Generates per-stage stall signals; the hazard unit uses them to hold IF/ID and EX/MEM.
- A 1-entry fetch buffer keeps a completed fetch available while the front end is frozen.

---
 rtl/pipe_mem_pkg.sv | 19 +
 rtl/fetch_buf1.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mem_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter.
package pipe_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic OWN_IF   = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  // Wide enough to hold any value 0..mem_lat.
  function automatic int cnt_width(input int mem_lat);
    return $clog2(mem_lat + 1);
  endfunction

endpackage

// File: rtl/fetch_buf1.sv
// One-entry fetch buffer: remembers the last completed fetch so a frozen
// front end can re-read it without touching memory.
module fetch_buf1 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fill,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              lookup_req,
  input  logic [ADDR_W-1:0] lookup_addr,
  input  logic              flush,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);

  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;

  assign hit      = buf_valid_q & lookup_req & (lookup_addr == buf_addr_q) & ~flush;
  assign hit_data = buf_data_q;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    if (fill) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = fill_addr;
      buf_data_d  = fill_data;
    end else if (flush | (lookup_req & (lookup_addr != buf_addr_q))) begin
      // Any redirect or move to a new address makes the entry stale.
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port fixed-latency memory between instruction fetch and
// MEM-stage data access; data wins, every access runs IDLE->ISSUE->WAIT->DONE.
module mem_port_arbiter
  import pipe_mem_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              stall_if,
  input  logic              dm_req,
  input  logic              dm_wen,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              stall_mem,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = cnt_width(MEM_LAT);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              cancel_q, cancel_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;

  logic              buf_hit;
  logic [DATA_W-1:0] buf_data;
  logic              buf_fill;
  logic              fetch_pending;

  fetch_buf1 #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fetch_buf (
    .clk        (clk),
    .reset      (reset),
    .fill       (buf_fill),
    .fill_addr  (mem_addr_q),
    .fill_data  (mem_rdata),
    .lookup_req (if_req),
    .lookup_addr(if_addr),
    .flush      (if_flush),
    .hit        (buf_hit),
    .hit_data   (buf_data)
  );

  assign fetch_pending = if_req & ~if_flush & ~buf_hit;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    cancel_d    = cancel_q;
    wen_d       = wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_rdata_d  = if_rdata_q;
    buf_fill    = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    dm_valid    = 1'b0;
    dm_rdata    = dm_rdata_q;
    // A buffer hit is served in any state, independent of the memory FSM.
    if_valid    = buf_hit;
    if_rdata    = buf_hit ? buf_data : if_rdata_q;

    unique case (state_q)
      IDLE: begin
        cancel_d = 1'b0;
        if (dm_req) begin
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          wen_d       = dm_wen;
          owner_d     = OWN_DATA;
          state_d     = ISSUE;
        end else if (fetch_pending) begin
          mem_addr_d = if_addr;
          wen_d      = 1'b0;
          owner_d    = OWN_IF;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        mem_en  = 1'b1;
        mem_we  = wen_q;
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = (MEM_LAT == 1) ? DONE : WAIT;
        if ((owner_q == OWN_IF) && if_flush) cancel_d = 1'b1;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
        if ((owner_q == OWN_IF) && if_flush) cancel_d = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        if (owner_q == OWN_DATA) begin
          dm_valid = 1'b1;
          if (!wen_q) begin
            dm_rdata   = mem_rdata;
            dm_rdata_d = mem_rdata;
          end
        end else if (!cancel_q && !if_flush) begin
          if_valid   = 1'b1;
          if_rdata   = mem_rdata;
          if_rdata_d = mem_rdata;
          buf_fill   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign stall_mem = dm_req & ~dm_valid;
  assign stall_if  = if_req & ~if_valid & ~if_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= OWN_IF;
      cancel_q    <= 1'b0;
      wen_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dm_rdata_q  <= '0;
      if_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      cancel_q    <= cancel_d;
      wen_q       <= wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_rdata_q  <= if_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle-count transaction model checks
// every output each cycle, plus hand-computed literal expectations.
module tb_mem_port_arbiter;

  localparam int LAT_A = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        if_req, if_flush, dm_req, dm_wen;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_valid, stall_if, dm_valid, stall_mem, mem_en, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        if_req_b, if_flush_b, dm_req_b, dm_wen_b;
  logic [31:0] if_addr_b, dm_addr_b, dm_wdata_b;
  logic        if_valid_b, stall_if_b, dm_valid_b, stall_mem_b, mem_en_b, mem_we_b;
  logic [31:0] if_rdata_b, dm_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

  mem_port_arbiter #(.MEM_LAT(LAT_A), .ADDR_W(32), .DATA_W(32)) dut_a (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_rdata(if_rdata), .stall_if(stall_if),
    .dm_req(dm_req), .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_valid(dm_valid), .dm_rdata(dm_rdata), .stall_mem(stall_mem),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.MEM_LAT(1), .ADDR_W(32), .DATA_W(32)) dut_b (
    .clk(clk), .reset(reset),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_flush(if_flush_b),
    .if_valid(if_valid_b), .if_rdata(if_rdata_b), .stall_if(stall_if_b),
    .dm_req(dm_req_b), .dm_wen(dm_wen_b), .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b),
    .dm_valid(dm_valid_b), .dm_rdata(dm_rdata_b), .stall_mem(stall_mem_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  function automatic logic [31:0] dflt(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
  endfunction

  // Memory: 1K words; reads return MEM_LAT cycles after the mem_en cycle.
  logic [31:0] mem_arr [1024];
  logic [31:0] pipe_a [LAT_A];
  logic [31:0] pipe_b;

  initial begin
    for (int i = 0; i < 1024; i++) mem_arr[i] = dflt(32'(i) << 2);
    forever begin
      @(posedge clk);
      if (mem_en && mem_we) mem_arr[mem_addr[11:2]] = mem_wdata;
    end
  end

  always @(posedge clk) begin
    pipe_a[0] <= (mem_en && !mem_we) ? mem_arr[mem_addr[11:2]] : 32'hBAD0_0000;
    for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
    pipe_b <= (mem_en_b && !mem_we_b) ? mem_arr[mem_addr_b[11:2]] : 32'hBAD1_0000;
  end
  assign mem_rdata   = pipe_a[LAT_A-1];
  assign mem_rdata_b = pipe_b;

  int vecs = 0;
  int errs = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: an access granted in cycle g issues in g+1 and
  // completes in g+1+LAT_A; the arbiter is free again the cycle after.
  bit          mdl_on = 1'b0;
  int          m_cyc, m_iss;
  bit          m_busy, m_own_data, m_we, m_cancel, m_bv;
  logic [31:0] m_addr, m_wdata, m_rd, m_ba, m_bd, m_if_hold, m_dm_hold;
  logic [31:0] m_last_addr, m_last_wdata;
  logic [31:0] m_mem [1024];
  bit          e_issue, e_done, e_hit, e_done_if, e_ifv, e_dmv;
  logic [31:0] e_ifr, e_dmr;

  initial begin
    for (int i = 0; i < 1024; i++) m_mem[i] = dflt(32'(i) << 2);
    m_cyc = 0; m_iss = 0; m_busy = 0; m_own_data = 0; m_we = 0; m_cancel = 0; m_bv = 0;
    m_addr = 0; m_wdata = 0; m_rd = 0; m_ba = 0; m_bd = 0; m_if_hold = 0; m_dm_hold = 0;
    m_last_addr = 0; m_last_wdata = 0;
    forever begin
      @(negedge clk);
      if (mdl_on) begin
        e_issue   = m_busy && (m_cyc == m_iss);
        e_done    = m_busy && (m_cyc == m_iss + LAT_A);
        e_hit     = m_bv && if_req && (if_addr == m_ba) && !if_flush;
        e_done_if = e_done && !m_own_data && !m_cancel && !if_flush;
        e_ifv     = e_hit || e_done_if;
        e_ifr     = e_done_if ? m_rd : (e_hit ? m_bd : m_if_hold);
        e_dmv     = e_done && m_own_data;
        e_dmr     = (e_dmv && !m_we) ? m_rd : m_dm_hold;

        check1 ("mdl_if_valid",  if_valid,  e_ifv);
        check32("mdl_if_rdata",  if_rdata,  e_ifr);
        check1 ("mdl_dm_valid",  dm_valid,  e_dmv);
        check32("mdl_dm_rdata",  dm_rdata,  e_dmr);
        check1 ("mdl_mem_en",    mem_en,    e_issue);
        check1 ("mdl_mem_we",    mem_we,    e_issue && m_we);
        check32("mdl_mem_addr",  mem_addr,  m_last_addr);
        check32("mdl_mem_wdata", mem_wdata, m_last_wdata);
        check1 ("mdl_stall_mem", stall_mem, dm_req && !e_dmv);
        check1 ("mdl_stall_if",  stall_if,  if_req && !e_ifv && !if_flush);

        if (e_issue) begin
          if (m_we) m_mem[m_addr[11:2]] = m_wdata;
          else      m_rd = m_mem[m_addr[11:2]];
        end
        if (reset) begin
          m_busy = 0; m_own_data = 0; m_we = 0; m_cancel = 0; m_bv = 0;
          m_ba = 0; m_bd = 0; m_if_hold = 0; m_dm_hold = 0;
          m_last_addr = 0; m_last_wdata = 0;
        end else begin
          if (e_done_if) begin
            m_bv = 1; m_ba = m_addr; m_bd = m_rd; m_if_hold = m_rd;
          end else if (if_flush || (if_req && if_addr != m_ba)) begin
            m_bv = 0;
          end
          if (e_dmv && !m_we) m_dm_hold = m_rd;
          if (m_busy && !e_done && !m_own_data && if_flush) m_cancel = 1;
          if (e_done) begin
            m_busy = 0;
          end else if (!m_busy) begin
            if (dm_req) begin
              m_busy = 1; m_iss = m_cyc + 1; m_own_data = 1; m_cancel = 0;
              m_addr = dm_addr; m_we = dm_wen; m_wdata = dm_wdata;
              m_last_addr = dm_addr; m_last_wdata = dm_wdata;
            end else if (if_req && !if_flush && !e_hit) begin
              m_busy = 1; m_iss = m_cyc + 1; m_own_data = 0; m_cancel = 0;
              m_addr = if_addr; m_we = 0; m_last_addr = if_addr;
            end
          end
        end
      end
      m_cyc++;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Leaves the caller at the sampling point of the valid cycle.
  task automatic wait_valid(input bit data, input string name);
    int n;
    n = 0;
    smp();
    while (((data ? dm_valid : if_valid) == 1'b0) && n < 20) begin
      nxt();
      smp();
      n++;
    end
    check1(name, data ? dm_valid : if_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    if_req = 0; if_flush = 0; if_addr = 0; dm_req = 0; dm_wen = 0; dm_addr = 0; dm_wdata = 0;
    if_req_b = 0; if_flush_b = 0; if_addr_b = 0; dm_req_b = 0; dm_wen_b = 0; dm_addr_b = 0; dm_wdata_b = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mdl_on = 1'b1;

    smp();
    check1("reset_if_valid", if_valid, 1'b0);
    check1("reset_mem_en", mem_en, 1'b0);
    check32("reset_mem_addr", mem_addr, 32'h0);
    nxt();

    // Single fetch, then buffer reuse, then move to a new address.
    if_req = 1; if_addr = 32'h100;
    smp(); check1("t1_c0_stall_if", stall_if, 1'b1); check1("t1_c0_mem_en", mem_en, 1'b0); nxt();
    smp(); check1("t1_c1_mem_en", mem_en, 1'b1); check32("t1_c1_mem_addr", mem_addr, 32'h100);
    check1("t1_c1_mem_we", mem_we, 1'b0); nxt();
    smp(); check1("t1_c2_if_valid", if_valid, 1'b0); check1("t1_c2_stall_if", stall_if, 1'b1); nxt();
    smp(); check1("t1_c3_if_valid", if_valid, 1'b1); check32("t1_c3_if_rdata", if_rdata, 32'hDEADBEEF);
    check1("t1_c3_stall_if", stall_if, 1'b0); nxt();
    for (int i = 0; i < 3; i++) begin
      smp(); check1("t4_hit_valid", if_valid, 1'b1); check1("t4_hit_no_mem_en", mem_en, 1'b0);
      check32("t4_hit_rdata", if_rdata, 32'hDEADBEEF); nxt();
    end
    if_addr = 32'h104;
    smp(); check1("t4_miss_valid", if_valid, 1'b0); nxt();
    smp(); check1("t4_miss_mem_en", mem_en, 1'b1); check32("t4_miss_addr", mem_addr, 32'h104); nxt();
    wait_valid(1'b0, "t4_miss_done"); nxt();
    if_req = 0; if_flush = 1;
    smp(); nxt();
    if_flush = 0;

    // Data and fetch together: data first, fetch after one idle cycle.
    dm_req = 1; dm_wen = 0; dm_addr = 32'h200; if_req = 1; if_addr = 32'h104;
    smp(); check1("t2_c0_stall_mem", stall_mem, 1'b1); nxt();
    smp(); check1("t2_c1_mem_en", mem_en, 1'b1); check32("t2_c1_addr", mem_addr, 32'h200); nxt();
    smp(); check1("t2_c2_dm_valid", dm_valid, 1'b0); nxt();
    smp(); check1("t2_c3_dm_valid", dm_valid, 1'b1); check32("t2_c3_dm_rdata", dm_rdata, dflt(32'h200));
    check1("t2_c3_stall_if", stall_if, 1'b1); nxt();
    dm_req = 0;
    smp(); check1("t2_c4_mem_en", mem_en, 1'b0); nxt();
    smp(); check1("t2_c5_mem_en", mem_en, 1'b1); check32("t2_c5_addr", mem_addr, 32'h104); nxt();
    smp(); check1("t2_c6_stall_if", stall_if, 1'b1); nxt();
    smp(); check1("t2_c7_if_valid", if_valid, 1'b1); check32("t2_c7_if_rdata", if_rdata, dflt(32'h104)); nxt();
    if_req = 0;

    // Store leaves dm_rdata at its held value; a load reads it back.
    dm_req = 1; dm_wen = 1; dm_addr = 32'h300; dm_wdata = 32'h12345678;
    smp(); nxt();
    smp(); check1("t3_mem_en", mem_en, 1'b1); check1("t3_mem_we", mem_we, 1'b1);
    check32("t3_mem_wdata", mem_wdata, 32'h12345678); nxt();
    smp(); check1("t3_c2_mem_we", mem_we, 1'b0); nxt();
    smp(); check1("t3_dm_valid", dm_valid, 1'b1); check32("t3_dm_rdata_held", dm_rdata, dflt(32'h200)); nxt();
    dm_wen = 0; dm_wdata = 0;
    wait_valid(1'b1, "t3_readback_done"); check32("t3_readback", dm_rdata, 32'h12345678); nxt();
    dm_req = 0;

    // Flush during WAIT cancels the fetch; the next request issues normally.
    if_req = 1; if_addr = 32'h500;
    smp(); nxt();
    smp(); check32("t5_c1_addr", mem_addr, 32'h500); nxt();
    if_flush = 1; if_req = 0;
    smp(); check1("t5_c2_stall_if", stall_if, 1'b0); nxt();
    if_flush = 0; if_req = 1; if_addr = 32'h400;
    smp(); check1("t5_done_no_valid", if_valid, 1'b0); nxt();
    smp(); check1("t5_idle_mem_en", mem_en, 1'b0); nxt();
    smp(); check1("t5_reissue_en", mem_en, 1'b1); check32("t5_reissue_addr", mem_addr, 32'h400); nxt();
    wait_valid(1'b0, "t5_fetch400"); check32("t5_if_rdata", if_rdata, dflt(32'h400)); nxt();

    // Buffer hits continue while a data access is in flight.
    dm_req = 1; dm_addr = 32'h204;
    smp(); check1("t6_hit_c0", if_valid, 1'b1); nxt();
    smp(); check1("t6_data_en", mem_en, 1'b1); check1("t6_hit_c1", if_valid, 1'b1);
    check32("t6_hit_rdata", if_rdata, dflt(32'h400)); nxt();
    wait_valid(1'b1, "t6_data_done"); check32("t6_dm_rdata", dm_rdata, dflt(32'h204)); nxt();
    dm_req = 0; if_req = 0;

    // Flush in the DONE cycle suppresses if_valid and the buffer fill.
    if_req = 1; if_addr = 32'h600;
    nxt(); nxt(); nxt();
    if_flush = 1;
    smp(); check1("t7_done_flush_valid", if_valid, 1'b0); nxt();
    if_flush = 0;
    smp(); check1("t7_refetch_idle", if_valid, 1'b0); nxt();
    smp(); check1("t7_refetch_en", mem_en, 1'b1); check32("t7_refetch_addr", mem_addr, 32'h600); nxt();
    wait_valid(1'b0, "t7_refetch_done"); check32("t7_if_rdata", if_rdata, dflt(32'h600)); nxt();
    if_req = 0;

    // Reset during WAIT returns everything to zero and drops the read.
    if_req = 1; if_addr = 32'h700;
    nxt(); nxt();
    reset = 1; if_req = 0;
    smp(); nxt();
    reset = 0;
    smp();
    check1("t8_mem_en", mem_en, 1'b0); check1("t8_if_valid", if_valid, 1'b0);
    check1("t8_dm_valid", dm_valid, 1'b0); check32("t8_mem_addr", mem_addr, 32'h0);
    check32("t8_if_rdata", if_rdata, 32'h0); check32("t8_dm_rdata", dm_rdata, 32'h0);
    nxt();
    if_req = 1; if_addr = 32'h600;
    smp(); check1("t8_buf_cleared", if_valid, 1'b0); nxt();
    wait_valid(1'b0, "t8_fetch_after_reset"); nxt();
    if_req = 0;

    // MEM_LAT=1 instance: valid two cycles after the request.
    if_req_b = 1; if_addr_b = 32'h100;
    smp(); check1("b_c0_if_valid", if_valid_b, 1'b0); check1("b_c0_stall_if", stall_if_b, 1'b1); nxt();
    smp(); check1("b_c1_mem_en", mem_en_b, 1'b1); check32("b_c1_addr", mem_addr_b, 32'h100);
    check1("b_c1_if_valid", if_valid_b, 1'b0); nxt();
    smp(); check1("b_c2_if_valid", if_valid_b, 1'b1); check32("b_c2_if_rdata", if_rdata_b, 32'hDEADBEEF); nxt();
    if_req_b = 0;

    smp();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
